// File: rtl/sseg_pkg.sv
// Shared segment/code tables and scan FSM encoding
// for the 4-digit display capture path.
package sseg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_ERR   = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HOLD
  } scan_state_t;

endpackage

// File: rtl/sseg_pattern_decode.sv
// Active-low 7-segment pattern back to digit code,
// sharing the encoder's table.
module sseg_pattern_decode
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code
);

  // Table lookup; unknown patterns map to the error code
  always_comb begin
    code = CODE_ERR;
    unique case (1'b1)
      (seg == SEG_0):     code = 4'h0;
      (seg == SEG_1):     code = 4'h1;
      (seg == SEG_2):     code = 4'h2;
      (seg == SEG_3):     code = 4'h3;
      (seg == SEG_4):     code = 4'h4;
      (seg == SEG_5):     code = 4'h5;
      (seg == SEG_6):     code = 4'h6;
      (seg == SEG_7):     code = 4'h7;
      (seg == SEG_8):     code = 4'h8;
      (seg == SEG_9):     code = 4'h9;
      (seg == SEG_MINUS): code = CODE_MINUS;
      (seg == SEG_BLANK): code = CODE_BLANK;
      default:            code = CODE_ERR;
    endcase
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Watches the multiplexed SSeg/an bus and rebuilds
// the displayed 4-digit frame and its signed value.
module sseg_scan_capture
  import sseg_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  SSeg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [8:0]  value,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        stale
);

  localparam int SW = $clog2(SETTLE_CYC) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  scan_state_t state, state_nxt;
  logic [3:0]    cur_an, cur_an_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic [TW-1:0] timeout_cnt;
  logic [3:0]    mask;
  logic [15:0]   slots;
  logic [3:0]    code;
  logic          capture, mask_clr, done;
  logic          an_onehot, an_blank, an_glitch;
  logic [3:0]    d3, d2, d1, d0;
  logic [3:0]    n2, n1, n0;
  logic [9:0]    mag;
  logic          neg, err;
  logic [8:0]    val;

  sseg_pattern_decode u_dec (
    .seg  (SSeg),
    .code (code)
  );

  assign an_onehot = $onehot(~an);
  assign an_blank  = (an == 4'hF);
  assign an_glitch = !an_onehot && !an_blank;
  assign done      = (mask == 4'hF);

  // Scan state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_WAIT;
      cur_an     <= 4'hF;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      cur_an     <= cur_an_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // Next state: settle on a stable digit select, sample once
  always_comb begin
    state_nxt  = state;
    cur_an_nxt = cur_an;
    settle_nxt = settle_cnt;
    capture    = 1'b0;
    mask_clr   = 1'b0;
    if (an_glitch) begin
      state_nxt = ST_WAIT;
      mask_clr  = 1'b1;
    end else begin
      case (state)
        ST_WAIT: begin
          if (an_onehot) begin
            state_nxt  = ST_SETTLE;
            cur_an_nxt = an;
            settle_nxt = '0;
          end
        end
        ST_SETTLE: begin
          if (an_blank) begin
            state_nxt = ST_WAIT;
          end else if (an != cur_an) begin
            cur_an_nxt = an;
            settle_nxt = '0;
          end else if (settle_cnt == SW'(SETTLE_CYC - 2)) begin
            capture   = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            settle_nxt = settle_cnt + SW'(1);
          end
        end
        ST_HOLD: begin
          if (an != cur_an) begin
            if (an_onehot) begin
              state_nxt  = ST_SETTLE;
              cur_an_nxt = an;
              settle_nxt = '0;
            end else begin
              state_nxt = ST_WAIT;
            end
          end
        end
        default: state_nxt = ST_WAIT;
      endcase
    end
  end

  // Digit slots and seen-mask; completion restarts the mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask  <= '0;
      slots <= 16'hFFFF;
    end else begin
      if (mask_clr || done) mask <= '0;
      if (capture) begin
        mask <= (done ? 4'h0 : mask) | ~cur_an;
        for (int k = 0; k < 4; k++)
          if (!cur_an[k]) slots[k*4 +: 4] <= code;
      end
    end
  end

  // Frame value and validity from the captured codes
  always_comb begin
    d3  = slots[15:12];
    d2  = slots[11:8];
    d1  = slots[7:4];
    d0  = slots[3:0];
    n2  = (d2 == CODE_BLANK) ? 4'h0 : d2;
    n1  = (d1 == CODE_BLANK) ? 4'h0 : d1;
    n0  = (d0 == CODE_BLANK) ? 4'h0 : d0;
    mag = 10'(n2) * 10'd100 + 10'(n1) * 10'd10 + 10'(n0);
    neg = (d3 == CODE_MINUS);
    err = 1'b0;
    if (d3 == CODE_ERR || d2 == CODE_ERR ||
        d1 == CODE_ERR || d0 == CODE_ERR) err = 1'b1;
    if (d3 != CODE_MINUS && d3 != CODE_BLANK) err = 1'b1;
    if (d2 == CODE_MINUS || d1 == CODE_MINUS ||
        d0 == CODE_MINUS) err = 1'b1;
    if ((d2 != CODE_BLANK && d1 == CODE_BLANK) ||
        (d1 != CODE_BLANK && d0 == CODE_BLANK)) err = 1'b1;
    if (neg ? (mag > 10'd256) : (mag > 10'd255)) err = 1'b1;
    val = '0;
    if (!err) val = neg ? (~mag[8:0] + 9'd1) : mag[8:0];
  end

  // Registered frame outputs and staleness watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= 16'hFFFF;
      value       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      stale       <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      frame_valid <= done;
      if (done) begin
        digits      <= slots;
        value       <= val;
        frame_err   <= err;
        stale       <= 1'b0;
        timeout_cnt <= '0;
      end else if (!stale) begin
        if (timeout_cnt == TW'(TIMEOUT_CYC - 1))
          stale <= 1'b1;
        else
          timeout_cnt <= timeout_cnt + TW'(1);
      end
    end
  end

endmodule
